// File: rtl/hc_registered_mux_3s_pkg.sv
// Shared flat-bus indexing helper for parametrised component models.
// Used to locate bit b of input i of channel c on a flattened data bus.
package hc_registered_mux_3s_pkg;

  function automatic int flat_idx(input int c, input int i, input int b,
                                  input int inputs, input int width);
    return ((c * inputs) + i) * width + b;
  endfunction

endpackage

// File: rtl/hc_mux_slice.sv
// One mux channel: 2**SEL_W:1 select into a WIDTH-bit register with clock
// enable and asynchronous active-low reset.
module hc_mux_slice
  import hc_registered_mux_3s_pkg::*;
#(
  parameter int              WIDTH     = 1,
  parameter int              SEL_W     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          cp,
  input  logic                          mr_n,
  input  logic [(2**SEL_W)*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          ce_n,
  output logic [WIDTH-1:0]              q_p0
);

  localparam int INPUTS = 2 ** SEL_W;

  logic [WIDTH-1:0] in_arr [INPUTS];

  for (genvar i = 0; i < INPUTS; i++) begin : g_in
    assign in_arr[i] = din[flat_idx(0, i, 0, INPUTS, WIDTH) +: WIDTH];
  end

  // capture stage: single register, loads only while ce_n is low
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      q_p0 <= RESET_VAL;
    end else if (!ce_n) begin
      q_p0 <= in_arr[sel];
    end
  end

endmodule

// File: rtl/hc_registered_mux_3s.sv
// Registered multi-channel multiplexer with 3-state outputs and an optional
// auto-scan mode that steps through every input and pulses frame at the end.
module hc_registered_mux_3s
  import hc_registered_mux_3s_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               CHANNELS  = 4,
  parameter int               SEL_W     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                 cp,
  input  logic                                 mr_n,
  input  logic [CHANNELS*(2**SEL_W)*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]                     s,
  input  logic                                 scan,
  input  logic                                 ce_n,
  input  logic                                 oe_n,
  output logic [CHANNELS*WIDTH-1:0]            q,
  output logic [SEL_W-1:0]                     sel_q,
  output logic                                 frame
);

  localparam int INPUTS = 2 ** SEL_W;

  logic [SEL_W-1:0]          cnt;
  logic [SEL_W-1:0]          sel_eff;
  logic [CHANNELS*WIDTH-1:0] q_p0;

  assign sel_eff = scan ? cnt : s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    hc_mux_slice #(
      .WIDTH    (WIDTH),
      .SEL_W    (SEL_W),
      .RESET_VAL(RESET_VAL)
    ) u_slice (
      .cp  (cp),
      .mr_n(mr_n),
      .din (d[flat_idx(c, 0, 0, INPUTS, WIDTH) +: INPUTS*WIDTH]),
      .sel (sel_eff),
      .ce_n(ce_n),
      .q_p0(q_p0[c*WIDTH +: WIDTH])
    );
  end

  // capture stage: counter wraps naturally at 2**SEL_W; manual mode rearms it at 0
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      cnt   <= '0;
      sel_q <= '0;
      frame <= 1'b0;
    end else if (!ce_n) begin
      sel_q <= sel_eff;
      frame <= scan && (sel_eff == '1);
      cnt   <= scan ? cnt + 1'b1 : '0;
    end else begin
      frame <= 1'b0;
    end
  end

  assign q = oe_n ? {(CHANNELS*WIDTH){1'bz}} : q_p0;

endmodule
